// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the pipeline control slice:
// opcodes, ALU ops, write-back sources and controller states.
package riscv_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned WB_W  = 2;

  // Major opcodes, instruction bits [6:2]
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [WB_W-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_LOAD_USE = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    a_sel;
    logic    b_sel;
  } dec_ctrl_t;

  // Opcodes that produce a register-file result
  function automatic logic writes_rd(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP,
      OPC_LUI, OPC_JALR, OPC_JAL: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Decode-stage ALU operation and operand selects; purely combinational.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  output dec_ctrl_t        ctrl
);

  always_comb begin
    ctrl.alu_op = ALU_ADD;
    ctrl.a_sel  = 1'b1;
    ctrl.b_sel  = 1'b1;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        ctrl.b_sel = (opcode == OPC_OP_IMM);
        case (funct3)
          3'b000: begin
            // Immediate form has no subtract; bit 30 is immediate data there
            if (opcode == OPC_OP && funct7_b5) ctrl.alu_op = ALU_SUB;
            else                               ctrl.alu_op = ALU_ADD;
          end
          3'b001: ctrl.alu_op = ALU_SLL;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b101: begin
            if (funct7_b5) ctrl.alu_op = ALU_SRA;
            else           ctrl.alu_op = ALU_SRL;
          end
          3'b110: ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_BRANCH, OPC_JAL, OPC_AUIPC: ctrl.a_sel  = 1'b0;
      OPC_LUI:                        ctrl.alu_op = ALU_PASS_B;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: decode control, forwarding, memory-wait/load-use
// stalls and jump/branch redirect sequencing.
module pipeline_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  instruction,
  input  logic [XLEN-1:0]  instruction_ppl,
  input  logic             br_taken,
  input  logic             dmem_ready,
  output logic [ALU_W-1:0] ALUctrl,
  output logic             A_sel,
  output logic             B_sel,
  output logic             forw_a,
  output logic             forw_b,
  output logic             reg_wr,
  output logic [WB_W-1:0]  wb_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             stall,
  output logic             flush
);

  dec_ctrl_t        dec_ctrl;
  logic [OPC_W-1:0] dec_opc, ex_opc;
  logic [REG_W-1:0] rs1, rs2, ex_rd;
  logic             ex_load, ex_store, ex_mem, ex_wr;
  logic             dec_redirect, ld_use_hit, fwd_a_raw, fwd_b_raw;
  wb_sel_e          ex_wb;
  state_e           state, state_nxt;
  logic             unused_bits;

  ctrl_decoder u_dec (
    .opcode    (dec_opc),
    .funct3    (instruction[14:12]),
    .funct7_b5 (instruction[30]),
    .ctrl      (dec_ctrl)
  );

  assign ALUctrl = dec_ctrl.alu_op;
  assign A_sel   = dec_ctrl.a_sel;
  assign B_sel   = dec_ctrl.b_sel;

  assign dec_opc = instruction[6:2];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];
  assign ex_opc  = instruction_ppl[6:2];
  assign ex_rd   = instruction_ppl[11:7];

  assign unused_bits = ^{instruction[31], instruction[29:25], instruction[11:7],
                         instruction[1:0], instruction_ppl[31:12], instruction_ppl[1:0]};

  assign ex_load  = (ex_opc == OPC_LOAD);
  assign ex_store = (ex_opc == OPC_STORE);
  assign ex_mem   = ex_load | ex_store;
  assign ex_wr    = writes_rd(ex_opc) && (ex_rd != '0);

  assign fwd_a_raw  = ex_wr && !ex_load && (ex_rd == rs1);
  assign fwd_b_raw  = ex_wr && !ex_load && (ex_rd == rs2);
  assign ld_use_hit = ex_load && ex_wr && ((ex_rd == rs1) || (ex_rd == rs2));

  assign dec_redirect = (dec_opc == OPC_JAL) || (dec_opc == OPC_JALR) ||
                        ((dec_opc == OPC_BRANCH) && br_taken);

  always_comb begin
    if (ex_load)                                    ex_wb = WB_MEM;
    else if (ex_opc == OPC_JAL || ex_opc == OPC_JALR) ex_wb = WB_PC4;
    else                                            ex_wb = WB_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next state and Mealy outputs; reset forces everything idle immediately
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    flush     = 1'b0;
    reg_wr    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    forw_a    = fwd_a_raw;
    forw_b    = fwd_b_raw;
    wb_sel    = ex_wb;

    case (state)
      S_RUN, S_MEM_WAIT: begin
        state_nxt = S_RUN;
        if (ex_mem) begin
          dmem_req = 1'b1;
          dmem_we  = ex_store;
          if (!dmem_ready) begin
            stall     = 1'b1;
            state_nxt = S_MEM_WAIT;
          end else if (ld_use_hit) begin
            stall     = 1'b1;
            reg_wr    = 1'b1;
            state_nxt = S_LOAD_USE;
          end else begin
            reg_wr = ex_load && ex_wr;
          end
        end else begin
          reg_wr = ex_wr;
        end
        if (!stall && dec_redirect) state_nxt = S_REDIRECT;
      end
      S_LOAD_USE: begin
        // Load still sits in execute; its data is already in the register file
        forw_a    = 1'b0;
        forw_b    = 1'b0;
        state_nxt = dec_redirect ? S_REDIRECT : S_RUN;
      end
      default: begin
        flush     = 1'b1;
        reg_wr    = ex_wr && !ex_mem;
        state_nxt = S_RUN;
      end
    endcase

    if (rst) begin
      state_nxt = S_RUN;
      stall     = 1'b0;
      flush     = 1'b0;
      reg_wr    = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      forw_a    = 1'b0;
      forw_b    = 1'b0;
      wb_sel    = WB_ALU;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stimulus pushes expected outputs into a
// scoreboard queue, a monitor pops and compares at each falling edge.
module tb_pipeline_ctrl;

  logic        clk, rst;
  logic [31:0] instruction, instruction_ppl;
  logic        br_taken, dmem_ready;
  logic [3:0]  ALUctrl;
  logic        A_sel, B_sel, forw_a, forw_b, reg_wr;
  logic [1:0]  wb_sel;
  logic        dmem_req, dmem_we, stall, flush;

  pipeline_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .instruction_ppl (instruction_ppl),
    .br_taken        (br_taken),
    .dmem_ready      (dmem_ready),
    .ALUctrl         (ALUctrl),
    .A_sel           (A_sel),
    .B_sel           (B_sel),
    .forw_a          (forw_a),
    .forw_b          (forw_b),
    .reg_wr          (reg_wr),
    .wb_sel          (wb_sel),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .stall           (stall),
    .flush           (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {ALUctrl, A_sel, B_sel, forw_a, forw_b, reg_wr, wb_sel, dmem_req, dmem_we, stall, flush}
  localparam logic [14:0] M_ALL  = 15'h7FFF;
  localparam logic [14:0] M_NOWB = 15'h7FCF;
  localparam logic [14:0] M_NOA  = 15'h7BCF;

  typedef struct {
    string       name;
    logic [14:0] exp;
    logic [14:0] mask;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [14:0] ev(input logic [3:0] alu, input logic a, input logic b,
                                     input logic fa, input logic fb, input logic rw,
                                     input logic [1:0] wb, input logic rq, input logic we,
                                     input logic st, input logic fl);
    return {alu, a, b, fa, fb, rw, wb, rq, we, st, fl};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic step(input string nm, input logic r, input logic [31:0] di,
                      input logic [31:0] pi, input logic br, input logic rdy,
                      input logic [14:0] ex, input logic [14:0] mk);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst             = r;
    instruction     = di;
    instruction_ppl = pi;
    br_taken        = br;
    dmem_ready      = rdy;
    it.name = nm;
    it.exp  = ex;
    it.mask = mk;
    sb_q.push_back(it);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  initial begin
    sb_item_t    it;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {ALUctrl, A_sel, B_sel, forw_a, forw_b, reg_wr, wb_sel,
               dmem_req, dmem_we, stall, flush};
        checks++;
        if ((act & it.mask) !== (it.exp & it.mask)) begin
          errors++;
          $display("FAIL %s: got %h expected %h (mask %h)", it.name, act, it.exp, it.mask);
        end
      end
    end
  end

  logic [31:0] nopi, add3, sub4, lw5, add6, sw5, beq, jal1, jal0;

  initial begin
    nopi = 32'h0000_007F;
    add3 = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    sub4 = r_type(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
    lw5  = i_type(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    add6 = r_type(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
    sw5  = s_type(12'd4, 5'd5, 5'd1);
    beq  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    jal1 = jal(5'd1, 21'd8);
    jal0 = jal(5'd0, 21'd8);

    rst = 1'b1; instruction = nopi; instruction_ppl = nopi;
    br_taken = 1'b0; dmem_ready = 1'b0;

    step("reset_idle",   1, nopi, lw5,  0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), M_ALL);
    step("fwd_a_sub",    0, sub4, add3, 0, 0, ev(1,1,0,1,0,1,0,0,0,0,0), M_ALL);
    // load held off by memory for three cycles
    step("lw_wait1",     0, nopi, lw5,  0, 0, ev(0,1,1,0,0,0,0,1,0,1,0), M_NOWB);
    step("lw_wait2",     0, nopi, lw5,  0, 0, ev(0,1,1,0,0,0,0,1,0,1,0), M_NOWB);
    step("lw_wait3",     0, nopi, lw5,  0, 0, ev(0,1,1,0,0,0,0,1,0,1,0), M_NOWB);
    step("lw_done",      0, nopi, lw5,  0, 1, ev(0,1,1,0,0,1,1,1,0,0,0), M_ALL);
    step("bubble",       0, nopi, nopi, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), M_NOWB);
    // load-use
    step("ldu_stall",    0, add6, lw5,  0, 1, ev(0,1,0,0,0,1,1,1,0,1,0), M_ALL);
    step("ldu_cycle",    0, add6, lw5,  0, 1, ev(0,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("ldu_after",    0, nopi, add6, 0, 0, ev(0,1,1,0,0,1,0,0,0,0,0), M_ALL);
    step("store",        0, nopi, sw5,  0, 1, ev(0,1,1,0,0,0,0,1,1,0,0), M_NOWB);
    // branches
    step("beq_taken",    0, beq,  nopi, 1, 0, ev(0,0,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("beq_flush",    0, nopi, beq,  0, 0, ev(0,1,1,0,0,0,0,0,0,0,1), M_NOWB);
    step("beq_not",      0, beq,  nopi, 0, 0, ev(0,0,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("beq_noflush",  0, nopi, beq,  0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), M_NOWB);
    // jumps
    step("jal_x1",       0, jal1, nopi, 0, 0, ev(0,0,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("jal_x1_flush", 0, nopi, jal1, 0, 0, ev(0,1,1,0,0,1,2,0,0,0,1), M_ALL);
    step("jal_x0",       0, jal0, nopi, 0, 0, ev(0,0,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("jal_x0_flush", 0, nopi, jal0, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,1), M_NOWB);
    // memory wait outranks a pending jump
    step("prio_wait",    0, jal1, lw5,  0, 0, ev(0,0,1,0,0,0,0,1,0,1,0), M_NOWB);
    step("prio_done",    0, jal1, lw5,  0, 1, ev(0,0,1,0,0,1,1,1,0,0,0), M_ALL);
    step("prio_flush",   0, nopi, jal1, 0, 0, ev(0,1,1,0,0,1,2,0,0,0,1), M_ALL);
    // reset in the middle of a memory wait
    step("sw_wait1",     0, nopi, sw5,  0, 0, ev(0,1,1,0,0,0,0,1,1,1,0), M_NOWB);
    step("sw_wait2",     0, nopi, sw5,  0, 0, ev(0,1,1,0,0,0,0,1,1,1,0), M_NOWB);
    step("rst_in_wait",  1, nopi, sw5,  0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), M_ALL);
    step("run_after_rst",0, nopi, sw5,  0, 1, ev(0,1,1,0,0,0,0,1,1,0,0), M_NOWB);
    // forwarding on rs2 and rd=x0
    step("fwd_b",        0, r_type(7'h00, 5'd3, 5'd1, 3'b000, 5'd9), add3, 0, 0,
         ev(0,1,0,0,1,1,0,0,0,0,0), M_ALL);
    step("rd_x0",        0, r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd9),
         r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 0, 0, ev(0,1,0,0,0,0,0,0,0,0,0), M_ALL);
    // decoder table
    step("dec_sra",  0, r_type(7'h20, 5'd3, 5'd2, 3'b101, 5'd1), nopi, 0, 0, ev(7,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_srl",  0, r_type(7'h00, 5'd3, 5'd2, 3'b101, 5'd1), nopi, 0, 0, ev(6,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_sll",  0, r_type(7'h00, 5'd3, 5'd2, 3'b001, 5'd1), nopi, 0, 0, ev(2,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_slt",  0, r_type(7'h00, 5'd3, 5'd2, 3'b010, 5'd1), nopi, 0, 0, ev(3,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_sltu", 0, r_type(7'h00, 5'd3, 5'd2, 3'b011, 5'd1), nopi, 0, 0, ev(4,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_xor",  0, r_type(7'h00, 5'd3, 5'd2, 3'b100, 5'd1), nopi, 0, 0, ev(5,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_or",   0, r_type(7'h00, 5'd3, 5'd2, 3'b110, 5'd1), nopi, 0, 0, ev(8,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_and",  0, r_type(7'h00, 5'd3, 5'd2, 3'b111, 5'd1), nopi, 0, 0, ev(9,1,0,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_addi_b30", 0, i_type(12'h400, 5'd2, 3'b000, 5'd7, 7'b0010011), nopi, 0, 0,
         ev(0,1,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_srai", 0, i_type(12'h403, 5'd2, 3'b101, 5'd7, 7'b0010011), nopi, 0, 0,
         ev(7,1,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_lui",  0, {20'h12345, 5'd8, 7'b0110111}, nopi, 0, 0, ev(10,1,1,0,0,0,0,0,0,0,0), M_NOA);
    step("dec_auipc",0, {20'h12345, 5'd8, 7'b0010111}, nopi, 0, 0, ev(0,0,1,0,0,0,0,0,0,0,0), M_NOWB);
    step("dec_unknown", 0, 32'hFFFF_FFFF, nopi, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), M_NOWB);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 instruction  in  32  instruction in decode stage.
REQ-004 instruction_ppl  in  32  instruction in execute stage (decode/exec register output).
REQ-005 br_taken  in  1  branch-condition result for the decode-stage instruction.
REQ-006 dmem_ready  in  1  data memory completes the current request this cycle.
REQ-007 ALUctrl  out  4  ALU operation for the decode-stage instruction.
REQ-008 A_sel  out  1  1 = rs1 operand, 0 = PC.
REQ-009 B_sel  out  1  1 = immediate, 0 = rs2 operand.
REQ-010 forw_a, forw_b  out  1 each  select execute-stage ALU result for rs1/rs2.
REQ-011 reg_wr  out  1  register-file write enable for the execute-stage rd.
REQ-012 wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 PC+4.
REQ-013 dmem_req, dmem_we  out  1 each  data-memory request and write qualifier.
REQ-014 stall, flush  out  1 each  hold decode/exec registers; squash and redirect to the execute-stage ALU result.

Function
REQ-015 Decode-stage opcode [6:2] SHALL set ALUctrl/A_sel/B_sel: R/I-ALU per funct3/funct7 with A=rs1; load/store/jalr ADD, A=rs1, B=imm; branch/jal/auipc ADD, A=PC, B=imm; lui PASS_B, B=imm.
REQ-016 Unknown opcode SHALL decode as NOP: ALUctrl ADD, A_sel=1, B_sel=1, no write, no memory request.
REQ-017 forw_a SHALL be 1 iff the execute instruction writes rd, rd!=0, rd==instruction[19:15], and it is not a load; forw_b likewise on instruction[24:20].
REQ-018 FSM states: RUN, MEM_WAIT, LOAD_USE, REDIRECT.
REQ-019 RUN: execute-stage load/store SHALL assert dmem_req (dmem_we=1 for store); if dmem_ready=0, stall=1 and next state MEM_WAIT.
REQ-020 MEM_WAIT: dmem_req held, stall=1 while dmem_ready=0; on dmem_ready=1 the completion rules (REQ-021/022) apply that cycle.
REQ-021 Load completion while the decode instruction reads the load's rd (rd!=0): stall=1 that cycle, reg_wr=1, next LOAD_USE.
REQ-022 Other completions: stall=0, reg_wr=1 for loads, next RUN.
REQ-023 LOAD_USE (exactly 1 cycle): stall=0, reg_wr=0, dmem_req=0, forw_a/forw_b=0; next RUN.
REQ-024 Decode-stage jal, jalr, or branch with br_taken=1, when stall=0, SHALL enter REDIRECT next cycle.
REQ-025 REDIRECT (exactly 1 cycle): flush=1, reg_wr follows the jump (jal/jalr write PC+4, wb_sel=2); next RUN; redirect detection suppressed this cycle.
REQ-026 reg_wr SHALL be 0 when execute rd=0, for stores/branches, and during stall=1 except the completion cycle.
REQ-027 Memory wait has priority over redirect; a pending redirect is taken on the first non-stalled cycle.

Reset
REQ-028 rst=1 SHALL force state RUN immediately; stall, flush, reg_wr, dmem_req, dmem_we, forw_a, forw_b = 0; wb_sel=0.
REQ-029 Reset mid-MEM_WAIT SHALL drop dmem_req with no write-back.

Structure
REQ-030 Package riscv_ctrl_pkg SHALL hold opcode constants, 4-bit ALU-op enum (ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10), wb_sel and FSM-state enums.
REQ-031 Combinational sub-module ctrl_decoder SHALL produce REQ-015/016 fields; FSM, forwarding and hazard logic live in pipeline_ctrl.

Verification
REQ-032 add x3,x1,x2 then sub x4,x3,x1 -> forw_a=1, forw_b=0, ALUctrl=1, no stall.
REQ-033 lw x5,0(x1) with dmem_ready low 3 cycles -> stall=1 for 3 cycles, reg_wr=1 on cycle 4 only.
REQ-034 lw x5 then add x6,x5,x5, dmem_ready=1 -> one extra stall, then LOAD_USE with forw_a=forw_b=0, reg_wr pulses once.
REQ-035 beq with br_taken=1 -> flush=1 exactly one cycle later; br_taken=0 -> flush stays 0.
REQ-036 jal x1,+8 -> flush=1 next cycle with reg_wr=1, wb_sel=2; writes to x0 give reg_wr=0.
REQ-037 rst asserted during MEM_WAIT -> dmem_req, stall drop same cycle; state RUN after release.
